robot_vacuum_controller: RTL

ROBOT_VACUUM_CONTROLLER -- requirements
Module: robot_vacuum_controller

---
 rtl/robot_vacuum_controller.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/robot_vacuum_controller.sv
// Robot vacuum run sequencer: IDLE -> UNDOCK -> CLEAN (<-> PAUSE) -> RETURN -> IDLE,
// with low-battery refusal/abort, user stop, obstacle pause and a saturating run counter.
module robot_vacuum_controller #(
    parameter int          UNDOCK_CYCLES = 4,
    parameter int          CLEAN_CYCLES  = 16,
    parameter int          DOCK_CYCLES   = 4,
    parameter logic [7:0]  LOW_BATT      = 8'd20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_cleaning,
    input  logic        stop,
    input  logic [7:0]  battery_level,
    input  logic        obstacle,
    output logic [2:0]  state,
    output logic        busy,
    output logic        motor_on,
    output logic        brush_on,
    output logic        clean_done,
    output logic        aborted,
    output logic        rejected,
    output logic [7:0]  runs_completed
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_UNDOCK = 3'd1,
        S_CLEAN  = 3'd2,
        S_PAUSE  = 3'd3,
        S_RETURN = 3'd4
    } state_t;

    localparam logic [7:0]  UNDOCK_LAST = 8'(UNDOCK_CYCLES - 1);
    localparam logic [15:0] CLEAN_LAST  = 16'(CLEAN_CYCLES - 1);
    localparam logic [7:0]  DOCK_LAST   = 8'(DOCK_CYCLES - 1);

    state_t      state_q;
    state_t      state_next;
    logic [7:0]  phase_cnt;
    logic [7:0]  phase_cnt_next;
    logic [15:0] clean_cnt;
    logic [15:0] clean_cnt_next;
    logic        success;
    logic        success_next;
    logic        start_prev;
    logic        done_next;
    logic        abort_next;
    logic        reject_next;
    logic [7:0]  runs_next;
    logic        start_evt;
    logic        low_batt;
    logic        quit;

    assign start_evt = start_cleaning & ~start_prev;
    assign low_batt  = battery_level < LOW_BATT;
    assign quit      = stop | low_batt;
    assign state     = state_q;

    always_comb begin
        state_next     = state_q;
        phase_cnt_next = phase_cnt;
        clean_cnt_next = clean_cnt;
        success_next   = success;
        done_next      = 1'b0;
        abort_next     = 1'b0;
        reject_next    = 1'b0;
        runs_next      = runs_completed;
        case (state_q)
            S_IDLE: begin
                if (start_evt) begin
                    if (low_batt) begin
                        reject_next = 1'b1;
                    end else begin
                        state_next     = S_UNDOCK;
                        phase_cnt_next = 8'd0;
                        success_next   = 1'b0;
                    end
                end
            end
            S_UNDOCK: begin
                if (quit) begin
                    state_next     = S_RETURN;
                    phase_cnt_next = 8'd0;
                    success_next   = 1'b0;
                end else if (phase_cnt == UNDOCK_LAST) begin
                    state_next     = S_CLEAN;
                    clean_cnt_next = 16'd0;
                end else begin
                    phase_cnt_next = phase_cnt + 8'd1;
                end
            end
            S_CLEAN: begin
                if (quit) begin
                    state_next     = S_RETURN;
                    phase_cnt_next = 8'd0;
                    success_next   = 1'b0;
                end else if (obstacle) begin
                    // The cycle that spots the obstacle still counts as cleaning time,
                    // except the last one, which must be repeated after the pause.
                    state_next     = S_PAUSE;
                    clean_cnt_next = (clean_cnt == CLEAN_LAST) ? clean_cnt : clean_cnt + 16'd1;
                end else if (clean_cnt == CLEAN_LAST) begin
                    state_next     = S_RETURN;
                    phase_cnt_next = 8'd0;
                    success_next   = 1'b1;
                end else begin
                    clean_cnt_next = clean_cnt + 16'd1;
                end
            end
            S_PAUSE: begin
                if (quit) begin
                    state_next     = S_RETURN;
                    phase_cnt_next = 8'd0;
                    success_next   = 1'b0;
                end else if (!obstacle) begin
                    state_next = S_CLEAN;
                end
            end
            S_RETURN: begin
                if (phase_cnt == DOCK_LAST) begin
                    state_next = S_IDLE;
                    if (success) begin
                        done_next = 1'b1;
                        runs_next = (runs_completed == 8'hFF) ? runs_completed
                                                              : runs_completed + 8'd1;
                    end else begin
                        abort_next = 1'b1;
                    end
                end else begin
                    phase_cnt_next = phase_cnt + 8'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            phase_cnt      <= 8'd0;
            clean_cnt      <= 16'd0;
            success        <= 1'b0;
            start_prev     <= 1'b1;
            busy           <= 1'b0;
            motor_on       <= 1'b0;
            brush_on       <= 1'b0;
            clean_done     <= 1'b0;
            aborted        <= 1'b0;
            rejected       <= 1'b0;
            runs_completed <= 8'd0;
        end else begin
            state_q        <= state_next;
            phase_cnt      <= phase_cnt_next;
            clean_cnt      <= clean_cnt_next;
            success        <= success_next;
            start_prev     <= start_cleaning;
            busy           <= (state_next != S_IDLE);
            motor_on       <= (state_next == S_UNDOCK) || (state_next == S_CLEAN) ||
                              (state_next == S_RETURN);
            brush_on       <= (state_next == S_CLEAN);
            clean_done     <= done_next;
            aborted        <= abort_next;
            rejected       <= reject_next;
            runs_completed <= runs_next;
        end
    end

endmodule
